// File: rtl/nand_seq_pkg.sv
// Shared types and micro-program tables for the NAND-only logic-operation sequencer.
// Every gate is expressed as a short sequence of NAND evaluations over three scratch registers.
package nand_seq_pkg;

    localparam int STEP_W = 3;

    typedef enum logic [2:0] {
        OP_NAND    = 3'd0,
        OP_AND     = 3'd1,
        OP_OR      = 3'd2,
        OP_NOR     = 3'd3,
        OP_XOR     = 3'd4,
        OP_XNOR    = 3'd5,
        OP_NOT_A   = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_A  = 3'd0,
        SEL_B  = 3'd1,
        SEL_S0 = 3'd2,
        SEL_S1 = 3'd3,
        SEL_S2 = 3'd4
    } sel_e;

    typedef enum logic [1:0] {
        DST_S0 = 2'd0,
        DST_S1 = 2'd1,
        DST_S2 = 2'd2
    } dst_e;

    typedef struct packed {
        sel_e src0;
        sel_e src1;
        dst_e dst;
        logic last;
    } uop_t;

    // Number of NAND evaluations each op needs; illegal ops need none.
    function automatic logic [STEP_W-1:0] op_steps(op_e op);
        case (op)
            OP_NAND:  return 3'd1;
            OP_AND:   return 3'd2;
            OP_OR:    return 3'd3;
            OP_NOR:   return 3'd4;
            OP_XOR:   return 3'd4;
            OP_XNOR:  return 3'd5;
            OP_NOT_A: return 3'd1;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic uop_t mk_uop(sel_e s0, sel_e s1, dst_e d, logic l);
        uop_t u;
        u.src0 = s0;
        u.src1 = s1;
        u.dst  = d;
        u.last = l;
        return u;
    endfunction

    // NOR extends OR and XNOR extends XOR, so shared prefixes decode identically.
    function automatic uop_t uop_decode(op_e op, logic [STEP_W-1:0] step);
        uop_t u;
        u = mk_uop(SEL_A, SEL_A, DST_S0, 1'b1);
        case (op)
            OP_NAND: u = mk_uop(SEL_A, SEL_B, DST_S0, 1'b1);
            OP_AND: begin
                case (step)
                    3'd0:    u = mk_uop(SEL_A, SEL_B, DST_S0, 1'b0);
                    default: u = mk_uop(SEL_S0, SEL_S0, DST_S1, 1'b1);
                endcase
            end
            OP_OR, OP_NOR: begin
                case (step)
                    3'd0:    u = mk_uop(SEL_A, SEL_A, DST_S0, 1'b0);
                    3'd1:    u = mk_uop(SEL_B, SEL_B, DST_S1, 1'b0);
                    3'd2:    u = mk_uop(SEL_S0, SEL_S1, DST_S2, op == OP_OR);
                    default: u = mk_uop(SEL_S2, SEL_S2, DST_S0, 1'b1);
                endcase
            end
            OP_XOR, OP_XNOR: begin
                case (step)
                    3'd0:    u = mk_uop(SEL_A, SEL_B, DST_S0, 1'b0);
                    3'd1:    u = mk_uop(SEL_A, SEL_S0, DST_S1, 1'b0);
                    3'd2:    u = mk_uop(SEL_B, SEL_S0, DST_S2, 1'b0);
                    3'd3:    u = mk_uop(SEL_S1, SEL_S2, DST_S0, op == OP_XOR);
                    default: u = mk_uop(SEL_S0, SEL_S0, DST_S1, 1'b1);
                endcase
            end
            OP_NOT_A: u = mk_uop(SEL_A, SEL_A, DST_S0, 1'b1);
            default:  u = mk_uop(SEL_A, SEL_A, DST_S0, 1'b1);
        endcase
        return u;
    endfunction

endpackage

// File: rtl/nand_unit.sv
// The single shared NAND datapath: purely combinational, one evaluation per use.
module nand_unit #(
    parameter int BIT_LEN = 1
) (
    input  logic [BIT_LEN-1:0] x0,
    input  logic [BIT_LEN-1:0] x1,
    output logic [BIT_LEN-1:0] y
);

    assign y = ~(x0 & x1);

endmodule

// File: rtl/nand_op_sequencer.sv
// Sequences logic operations as micro-programs of NAND evaluations on one shared nand_unit.
// Request and result each use valid/ready: a transfer happens on a rising edge where both are high.
module nand_op_sequencer
    import nand_seq_pkg::*;
#(
    parameter int BIT_LEN = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [BIT_LEN-1:0] a,
    input  logic [BIT_LEN-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] c,
    output logic               err,
    output logic [CNT_W-1:0]   nand_count,
    output state_e             state_dbg
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q;
    op_e                 op_q;
    logic [BIT_LEN-1:0]  a_q, b_q;
    logic [BIT_LEN-1:0]  s0_q, s1_q, s2_q;
    logic [BIT_LEN-1:0]  c_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    uop_t                uop;
    logic [BIT_LEN-1:0]  x0, x1, y;
    logic                accept;
    logic                illegal;

    assign uop     = uop_decode(op_q, step_q);
    assign accept  = in_valid && (state_q == IDLE);
    assign illegal = (op_q == OP_ILLEGAL);

    always_comb begin
        x0 = a_q;
        case (uop.src0)
            SEL_A:   x0 = a_q;
            SEL_B:   x0 = b_q;
            SEL_S0:  x0 = s0_q;
            SEL_S1:  x0 = s1_q;
            SEL_S2:  x0 = s2_q;
            default: x0 = a_q;
        endcase
    end

    always_comb begin
        x1 = a_q;
        case (uop.src1)
            SEL_A:   x1 = a_q;
            SEL_B:   x1 = b_q;
            SEL_S0:  x1 = s0_q;
            SEL_S1:  x1 = s1_q;
            SEL_S2:  x1 = s2_q;
            default: x1 = a_q;
        endcase
    end

    nand_unit #(.BIT_LEN(BIT_LEN)) u_nand (
        .x0 (x0),
        .x1 (x1),
        .y  (y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal ops still pass through one EXEC cycle (without evaluating) so their result timing is fixed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (illegal || uop.last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        c          = c_q;
        err        = err_q;
        nand_count = cnt_q;
        state_dbg  = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            op_q   <= OP_NAND;
            a_q    <= '0;
            b_q    <= '0;
            s0_q   <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            c_q    <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_e'(op);
                a_q    <= a;
                b_q    <= b;
                step_q <= '0;
                if (op_e'(op) == OP_ILLEGAL) begin
                    c_q   <= '0;
                    err_q <= 1'b1;
                end
            end
            if (state_q == EXEC && !illegal) begin
                cnt_q <= cnt_q + CNT_W'(1);
                case (uop.dst)
                    DST_S0:  s0_q <= y;
                    DST_S1:  s1_q <= y;
                    DST_S2:  s2_q <= y;
                    default: s0_q <= y;
                endcase
                if (uop.last) begin
                    c_q   <= y;
                    err_q <= 1'b0;
                end else begin
                    step_q <= step_q + STEP_W'(1);
                end
            end
        end
    end

endmodule
